// File: rtl/mvu_acc_out_stream_if.sv
// AXI4-Stream bundle for the accumulator output stream (data, valid, ready, last).
interface mvu_acc_out_stream_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/mvu_acc_out_stream.sv
// Buffers lock-step PE accumulator outputs in a small FIFO and re-emits them as an
// AXI4-Stream with tlast framing, feeding an early stall back to the MVAU control.
module mvu_acc_out_stream #(
  parameter int unsigned PE        = 2,
  parameter int unsigned TDstI     = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_MARGIN = 3,
  parameter int unsigned NF        = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  in_acc_v,
  input  logic [PE*TDstI-1:0]   in_acc,
  output logic                  acc_stall,
  mvu_acc_out_stream_if.master  m_axis,
  output logic                  ovf_err
);
  localparam int unsigned W  = PE * TDstI;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = (NF > 1) ? $clog2(NF) : 1;

  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - AF_MARGIN);
  localparam logic [FW-1:0] LAST     = FW'(NF - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          stall_q, stall_d;
  logic          ovf_q, ovf_d;
  logic          full, pop, wr_en;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
  always_comb begin
    full    = (cnt_q == FULL);
    pop     = (cnt_q != '0) && m_axis.tready;
    wr_en   = in_acc_v && (!full || pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    frm_d   = frm_q;
    ovf_d   = ovf_q | (in_acc_v & full & ~pop);
    if (wr_en) wr_d = wr_q + 1'b1;
    if (pop) begin
      rd_d  = rd_q + 1'b1;
      frm_d = (frm_q == LAST) ? '0 : frm_q + 1'b1;
    end
    if (wr_en && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!wr_en && pop) cnt_d = cnt_q - 1'b1;
    stall_d = (cnt_d >= STALL_TH);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      frm_q   <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      frm_q   <= frm_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en && !areset) mem_q[wr_q] <= in_acc;
  end

  assign m_axis.tvalid = (cnt_q != '0);
  assign m_axis.tdata  = m_axis.tvalid ? mem_q[rd_q] : '0;
  assign m_axis.tlast  = m_axis.tvalid && (frm_q == LAST);
  assign acc_stall     = stall_q;
  assign ovf_err       = ovf_q;
endmodule
